// File: rtl/ltpi_link_training_fsm.sv
// ltpi_link_training_fsm
// ----------------------
// LTPI link training and monitoring state machine for one link endpoint. Sits between the
// LTPI frame decoder (rx) and the frame encoder (tx). Training walks
// Detect -> Speed -> Advertise -> Configure (SCM) / Accept (HPM) -> Operational, picks the
// fastest speed both ends support, and supervises the operational link for lost or
// corrupted frames.
//
// Parameters
//   ROLE        0 = SCM (sends Configure, waits Accept), 1 = HPM (waits Configure, sends Accept)
//   SPD_W       width of the speed capability vectors, higher bit index = faster speed
//   DETECT_CNT  consecutive good Detect frames needed to leave Detect
//   SPEED_CNT   consecutive good Speed frames needed to leave Speed
//   ADV_CNT     consecutive good Advertise frames needed to leave / arm Advertise
//   LOST_THR    consecutive bad or missing frames in Operational that declare link loss
//   TMO_CYC     per-state timeout in clock cycles (Speed, Advertise, Configure, Accept)
//
// Ports
//   i_clk, i_reset_n        link clock, asynchronous active-low reset
//   i_rx_frm_vld            one-cycle strobe: decoded frame available
//   i_rx_frm_type           1 Detect, 2 Speed, 3 Advertise, 4 Configure, 5 Accept, 6 Default-IO
//   i_rx_crc_err            qualifies i_rx_frm_vld: frame failed CRC
//   i_rx_frm_miss           one-cycle strobe: expected frame slot passed without a frame
//   i_rx_spd_cap            remote speed capability, valid with a Speed frame
//   i_local_spd_cap         local speed capability (static)
//   i_force_retrain         level: hold the link in Detect
//   i_err_cnt_clr           clears the error counters
//   o_tx_frm_type           frame type the encoder sends next
//   o_state                 0 Detect .. 5 Operational, 6 LinkLost
//   o_speed_sel             one-hot negotiated speed, 0 until negotiated
//   o_link_up               high only in Operational
//   o_spd_mismatch          one-cycle pulse: no common speed
//   o_crc_err_cnt           saturating CRC error count
//   o_link_lost_cnt         saturating link-loss count
//
// Build option
//   LTPI_LINK_ERR_CNT_EN    when defined, the CRC-error and link-loss counters are built;
//                           otherwise both count outputs are tied to 0 and i_err_cnt_clr
//                           is ignored.

module ltpi_link_training_fsm #(
    parameter int unsigned ROLE       = 0,
    parameter int unsigned SPD_W      = 8,
    parameter int unsigned DETECT_CNT = 7,
    parameter int unsigned SPEED_CNT  = 7,
    parameter int unsigned ADV_CNT    = 7,
    parameter int unsigned LOST_THR   = 3,
    parameter int unsigned TMO_CYC    = 1_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_rx_frm_vld,
    input  logic [2:0]       i_rx_frm_type,
    input  logic             i_rx_crc_err,
    input  logic             i_rx_frm_miss,
    input  logic [SPD_W-1:0] i_rx_spd_cap,
    input  logic [SPD_W-1:0] i_local_spd_cap,
    input  logic             i_force_retrain,
    input  logic             i_err_cnt_clr,
    output logic [2:0]       o_tx_frm_type,
    output logic [2:0]       o_state,
    output logic [SPD_W-1:0] o_speed_sel,
    output logic             o_link_up,
    output logic             o_spd_mismatch,
    output logic [15:0]      o_crc_err_cnt,
    output logic [15:0]      o_link_lost_cnt
);

    // ------------------------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------------------------
    localparam int unsigned CNT_MAX =
        (DETECT_CNT > SPEED_CNT) ? ((DETECT_CNT > ADV_CNT) ? DETECT_CNT : ADV_CNT)
                                 : ((SPEED_CNT > ADV_CNT) ? SPEED_CNT : ADV_CNT);
    localparam int unsigned MCNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned LOST_W = $clog2(LOST_THR + 1);
    localparam int unsigned TMO_W  = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [MCNT_W-1:0] DET_THR  = MCNT_W'(DETECT_CNT);
    localparam logic [MCNT_W-1:0] SPD_THR  = MCNT_W'(SPEED_CNT);
    localparam logic [MCNT_W-1:0] ADV_THR  = MCNT_W'(ADV_CNT);
    localparam logic [LOST_W-1:0] LOST_LIM = LOST_W'(LOST_THR);
    localparam logic [TMO_W-1:0]  TMO_THR  = TMO_W'(TMO_CYC - 1);

    localparam logic [2:0] FRM_DETECT = 3'd1;
    localparam logic [2:0] FRM_SPEED  = 3'd2;
    localparam logic [2:0] FRM_ADV    = 3'd3;
    localparam logic [2:0] FRM_CFG    = 3'd4;
    localparam logic [2:0] FRM_ACC    = 3'd5;
    localparam logic [2:0] FRM_DIO    = 3'd6;

    typedef enum logic [2:0] {
        StDetect      = 3'd0,
        StSpeed       = 3'd1,
        StAdvertise   = 3'd2,
        StConfigure   = 3'd3,
        StAccept      = 3'd4,
        StOperational = 3'd5,
        StLinkLost    = 3'd6
    } state_t;

    // ------------------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------------------
    // Keep only the highest set bit: the fastest speed both ends support.
    function automatic logic [SPD_W-1:0] f_msb_onehot(input logic [SPD_W-1:0] v);
        logic [SPD_W-1:0] r;
        r = '0;
        for (int i = 0; i < SPD_W; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] f_tx_type(input state_t s);
        logic [2:0] t;
        case (s)
            StDetect:      t = FRM_DETECT;
            StSpeed:       t = FRM_SPEED;
            StAdvertise:   t = FRM_ADV;
            StConfigure:   t = FRM_CFG;
            StAccept:      t = FRM_ACC;
            StOperational: t = FRM_DIO;
            default:       t = FRM_DETECT;
        endcase
        return t;
    endfunction

    // ------------------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------------------
    state_t            r_state,     w_state_d;
    logic [MCNT_W-1:0] r_match,     w_match_d;
    logic              r_adv_done,  w_adv_done_d;
    logic [LOST_W-1:0] r_lost,      w_lost_d;
    logic [TMO_W-1:0]  r_tmo,       w_tmo_d;
    logic [SPD_W-1:0]  r_speed_sel, w_speed_d;
    logic              r_spd_mism,  w_mism_d;
    logic [2:0]        r_tx_type;
    logic              r_link_up;

    logic              w_good;
    logic              w_bad;
    logic              w_timed;
    logic [SPD_W-1:0]  w_common;
    logic [MCNT_W-1:0] w_match_inc;
    logic [LOST_W-1:0] w_lost_inc;

    // A miss strobe coinciding with a frame strobe counts as one bad event.
    assign w_good      = i_rx_frm_vld & ~i_rx_crc_err & ~i_rx_frm_miss;
    assign w_bad       = (i_rx_frm_vld & i_rx_crc_err) | i_rx_frm_miss;
    assign w_common    = i_local_spd_cap & i_rx_spd_cap;
    assign w_match_inc = r_match + 1'b1;
    assign w_lost_inc  = r_lost + 1'b1;
    assign w_timed     = (r_state == StSpeed)     || (r_state == StAdvertise) ||
                         (r_state == StConfigure) || (r_state == StAccept);

    // ------------------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_match_d    = r_match;
        w_adv_done_d = r_adv_done;
        w_lost_d     = r_lost;
        w_speed_d    = r_speed_sel;
        w_mism_d     = 1'b0;

        if (w_bad) begin
            w_match_d = '0;
        end

        if (i_force_retrain) begin
            w_state_d = StDetect;
        end else if (w_timed && (r_tmo == TMO_THR)) begin
            w_state_d = StDetect;
        end else begin
            case (r_state)
                StDetect: begin
                    if (w_good) begin
                        if (i_rx_frm_type == FRM_DETECT) begin
                            w_match_d = w_match_inc;
                            if (w_match_inc == DET_THR) begin
                                w_state_d = StSpeed;
                            end
                        end else begin
                            w_match_d = '0;
                        end
                    end
                end

                StSpeed: begin
                    if (w_good) begin
                        if (i_rx_frm_type == FRM_SPEED) begin
                            if (w_common == '0) begin
                                w_mism_d  = 1'b1;
                                w_state_d = StDetect;
                            end else begin
                                w_speed_d = f_msb_onehot(w_common);
                                w_match_d = w_match_inc;
                                if (w_match_inc == SPD_THR) begin
                                    w_state_d = StAdvertise;
                                end
                            end
                        end else begin
                            w_match_d = '0;
                        end
                    end
                end

                StAdvertise: begin
                    if (w_good) begin
                        if (i_rx_frm_type == FRM_ADV) begin
                            // HPM stays here once armed; the counter stops so it cannot wrap.
                            if (!r_adv_done) begin
                                w_match_d = w_match_inc;
                                if (w_match_inc == ADV_THR) begin
                                    if (ROLE == 0) begin
                                        w_state_d = StConfigure;
                                    end else begin
                                        w_adv_done_d = 1'b1;
                                    end
                                end
                            end
                        end else if ((ROLE != 0) && r_adv_done &&
                                     (i_rx_frm_type == FRM_CFG)) begin
                            w_state_d = StAccept;
                        end else begin
                            w_match_d = '0;
                        end
                    end
                end

                StConfigure: begin
                    if (w_good && (i_rx_frm_type == FRM_ACC)) begin
                        w_state_d = StOperational;
                    end
                end

                StAccept: begin
                    if (w_good && (i_rx_frm_type == FRM_DIO)) begin
                        w_state_d = StOperational;
                    end
                end

                StOperational: begin
                    if (w_bad) begin
                        w_lost_d = w_lost_inc;
                        if (w_lost_inc == LOST_LIM) begin
                            w_state_d = StLinkLost;
                        end
                    end else if (w_good) begin
                        w_lost_d = '0;
                    end
                end

                StLinkLost: begin
                    w_state_d = StDetect;
                end

                default: begin
                    w_state_d = StDetect;
                end
            endcase
        end

        // Every per-state counter restarts on a state change; a held retrain keeps Detect idle.
        if ((w_state_d != r_state) || i_force_retrain) begin
            w_match_d    = '0;
            w_adv_done_d = 1'b0;
            w_lost_d     = '0;
        end

        if (w_state_d == StDetect) begin
            w_speed_d = '0;
        end
    end

    always_comb begin
        w_tmo_d = '0;
        if ((w_state_d == r_state) && w_timed) begin
            w_tmo_d = r_tmo + 1'b1;
        end
    end

    // ------------------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StDetect;
            r_match     <= '0;
            r_adv_done  <= 1'b0;
            r_lost      <= '0;
            r_tmo       <= '0;
            r_speed_sel <= '0;
            r_spd_mism  <= 1'b0;
            r_tx_type   <= FRM_DETECT;
            r_link_up   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_match     <= w_match_d;
            r_adv_done  <= w_adv_done_d;
            r_lost      <= w_lost_d;
            r_tmo       <= w_tmo_d;
            r_speed_sel <= w_speed_d;
            r_spd_mism  <= w_mism_d;
            r_tx_type   <= f_tx_type(w_state_d);
            r_link_up   <= (w_state_d == StOperational);
        end
    end

    assign o_state        = r_state;
    assign o_tx_frm_type  = r_tx_type;
    assign o_speed_sel    = r_speed_sel;
    assign o_link_up      = r_link_up;
    assign o_spd_mismatch = r_spd_mism;

    // ------------------------------------------------------------------------------------
    // Error counters
    // ------------------------------------------------------------------------------------
`ifdef LTPI_LINK_ERR_CNT_EN
    logic [15:0] r_crc_cnt;
    logic [15:0] r_ll_cnt;
    logic        w_crc_ev;
    logic        w_ll_ev;

    assign w_crc_ev = i_rx_frm_vld & i_rx_crc_err;
    assign w_ll_ev  = (w_state_d == StLinkLost) && (r_state != StLinkLost);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_crc_cnt <= '0;
            r_ll_cnt  <= '0;
        end else if (i_err_cnt_clr) begin
            r_crc_cnt <= '0;
            r_ll_cnt  <= '0;
        end else begin
            if (w_crc_ev && (r_crc_cnt != 16'hFFFF)) begin
                r_crc_cnt <= r_crc_cnt + 16'd1;
            end
            if (w_ll_ev && (r_ll_cnt != 16'hFFFF)) begin
                r_ll_cnt <= r_ll_cnt + 16'd1;
            end
        end
    end

    assign o_crc_err_cnt   = r_crc_cnt;
    assign o_link_lost_cnt = r_ll_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr    = i_err_cnt_clr;
    assign o_crc_err_cnt   = 16'd0;
    assign o_link_lost_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ltpi_link_training_fsm.sv
// Bench for ltpi_link_training_fsm: one SCM (ROLE 0) and one HPM (ROLE 1) instance driven in
// lockstep. Each stimulus cycle runs a rule-level reference model and pushes the expected
// registered outputs into a per-instance queue; a monitor pops and compares after each clock.
`timescale 1ns/1ps

module tb_ltpi_link_training_fsm;

    localparam int TMO  = 40;
    localparam int DET  = 7;
    localparam int SPD  = 7;
    localparam int ADV  = 7;
    localparam int LOST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       vld  [2];
    logic [2:0] typ  [2];
    logic       crc  [2];
    logic       miss [2];
    logic [7:0] rcap [2];
    logic [7:0] lcap [2];
    logic       frc  [2];
    logic       clr  [2];

    logic [2:0]  tx   [2];
    logic [2:0]  st   [2];
    logic [7:0]  spd  [2];
    logic        up   [2];
    logic        mism [2];
    logic [15:0] crcc [2];
    logic [15:0] llc  [2];

    ltpi_link_training_fsm #(
        .ROLE(0), .SPD_W(8), .DETECT_CNT(DET), .SPEED_CNT(SPD), .ADV_CNT(ADV),
        .LOST_THR(LOST), .TMO_CYC(TMO)
    ) u_scm (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_frm_vld(vld[0]), .i_rx_frm_type(typ[0]),
        .i_rx_crc_err(crc[0]), .i_rx_frm_miss(miss[0]), .i_rx_spd_cap(rcap[0]),
        .i_local_spd_cap(lcap[0]), .i_force_retrain(frc[0]), .i_err_cnt_clr(clr[0]),
        .o_tx_frm_type(tx[0]), .o_state(st[0]), .o_speed_sel(spd[0]), .o_link_up(up[0]),
        .o_spd_mismatch(mism[0]), .o_crc_err_cnt(crcc[0]), .o_link_lost_cnt(llc[0])
    );

    ltpi_link_training_fsm #(
        .ROLE(1), .SPD_W(8), .DETECT_CNT(DET), .SPEED_CNT(SPD), .ADV_CNT(ADV),
        .LOST_THR(LOST), .TMO_CYC(TMO)
    ) u_hpm (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_frm_vld(vld[1]), .i_rx_frm_type(typ[1]),
        .i_rx_crc_err(crc[1]), .i_rx_frm_miss(miss[1]), .i_rx_spd_cap(rcap[1]),
        .i_local_spd_cap(lcap[1]), .i_force_retrain(frc[1]), .i_err_cnt_clr(clr[1]),
        .o_tx_frm_type(tx[1]), .o_state(st[1]), .o_speed_sel(spd[1]), .o_link_up(up[1]),
        .o_spd_mismatch(mism[1]), .o_crc_err_cnt(crcc[1]), .o_link_lost_cnt(llc[1])
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [2:0]  tx;
        logic [7:0]  spd;
        logic        up;
        logic        mism;
        logic [15:0] crc;
        logic [15:0] ll;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: link phase, frame counters, negotiated speed, error counts.
    int         m_st    [2];
    int         m_match [2];
    bit         m_armed [2];
    int         m_lost  [2];
    int         m_tmo   [2];
    logic [7:0] m_spd   [2];
    int         m_crc   [2];
    int         m_ll    [2];
    int         tx_of   [7] = '{1, 2, 3, 4, 5, 6, 1};
    int         want_of [5] = '{1, 2, 3, 5, 6};

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_match[k] = 0; m_armed[k] = 1'b0; m_lost[k] = 0;
            m_tmo[k] = 0; m_spd[k] = 8'h00; m_crc[k] = 0; m_ll[k] = 0;
        end
    endfunction

    function automatic exp_t model_step(int k);
        bit         good, bad, timed, mm;
        int         ns;
        logic [7:0] common, top;
        exp_t       e;
        good  = vld[k] && !crc[k] && !miss[k];
        bad   = (vld[k] && crc[k]) || miss[k];
        timed = (m_st[k] >= 1) && (m_st[k] <= 4);
        ns    = m_st[k];
        mm    = 1'b0;
        if (frc[k]) begin
            ns = 0;
        end else if (timed && m_tmo[k] == TMO - 1) begin
            ns = 0;
        end else begin
            if (bad) m_match[k] = 0;
            if (m_st[k] == 5) begin
                if (bad) begin
                    m_lost[k]++;
                    if (m_lost[k] == LOST) ns = 6;
                end else if (good) begin
                    m_lost[k] = 0;
                end
            end else if (m_st[k] == 6) begin
                ns = 0;
            end else if (good) begin
                if (int'(typ[k]) == want_of[m_st[k]]) begin
                    case (m_st[k])
                        0: begin
                            m_match[k]++;
                            if (m_match[k] == DET) ns = 1;
                        end
                        1: begin
                            common = lcap[k] & rcap[k];
                            if (common == 8'h00) begin
                                mm = 1'b1;
                                ns = 0;
                            end else begin
                                top = 8'h00;
                                for (int i = 7; i >= 0; i--) begin
                                    if (common[i]) begin
                                        top = 8'h01 << i;
                                        break;
                                    end
                                end
                                m_spd[k] = top;
                                m_match[k]++;
                                if (m_match[k] == SPD) ns = 2;
                            end
                        end
                        2: begin
                            if (!m_armed[k]) begin
                                m_match[k]++;
                                if (m_match[k] == ADV) begin
                                    if (k == 0) ns = 3;
                                    else m_armed[k] = 1'b1;
                                end
                            end
                        end
                        default: ns = 5;
                    endcase
                end else if (k == 1 && m_st[k] == 2 && m_armed[k] && typ[k] == 3'd4) begin
                    ns = 4;
                end else begin
                    m_match[k] = 0;
                end
            end
        end
        if (ns != m_st[k] || frc[k]) begin
            m_match[k] = 0; m_armed[k] = 1'b0; m_lost[k] = 0;
        end
        m_tmo[k] = (ns == m_st[k] && timed) ? m_tmo[k] + 1 : 0;
        if (ns == 0) m_spd[k] = 8'h00;
`ifdef LTPI_LINK_ERR_CNT_EN
        if (clr[k]) begin
            m_crc[k] = 0;
            m_ll[k]  = 0;
        end else begin
            if (vld[k] && crc[k] && m_crc[k] < 65535) m_crc[k]++;
            if (ns == 6 && m_st[k] != 6 && m_ll[k] < 65535) m_ll[k]++;
        end
`endif
        m_st[k] = ns;
        e.st   = 3'(ns);
        e.tx   = 3'(tx_of[ns]);
        e.spd  = m_spd[k];
        e.up   = (ns == 5);
        e.mism = mm;
        e.crc  = 16'(m_crc[k]);
        e.ll   = 16'(m_ll[k]);
        return e;
    endfunction

    // Monitor: compare one expected entry per instance after every clock edge.
    task automatic compare(int k, exp_t e);
        exp_t a;
        a = {st[k], tx[k], spd[k], up[k], mism[k], crcc[k], llc[k]};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL out%0d t=%0t got st=%0d tx=%0d spd=%h up=%b mm=%b crc=%0d ll=%0d want st=%0d tx=%0d spd=%h up=%b mm=%b crc=%0d ll=%0d",
                     k, $time, a.st, a.tx, a.spd, a.up, a.mism, a.crc, a.ll,
                     e.st, e.tx, e.spd, e.up, e.mism, e.crc, e.ll);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) compare(0, q0.pop_front());
            if (q1.size() > 0) compare(1, q1.pop_front());
        end
    end

    // One stimulus cycle: called just after a negedge with inputs set.
    task automatic step();
        q0.push_back(model_step(0));
        q1.push_back(model_step(1));
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; crc[k] = 1'b0; miss[k] = 1'b0; clr[k] = 1'b0;
        end
    endtask

    task automatic send(int k, int t, bit c, logic [7:0] cap, bit gaps);
        vld[k] = 1'b1; typ[k] = 3'(t); crc[k] = c; rcap[k] = cap;
        step();
        if (gaps) repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic send_miss(int k);
        miss[k] = 1'b1;
        step();
    endtask

    task automatic train(int k, logic [7:0] rc);
        repeat (DET) send(k, 1, 1'b0, 8'h00, 1'b1);
        repeat (SPD) send(k, 2, 1'b0, rc, 1'b1);
        repeat (ADV) send(k, 3, 1'b0, 8'h00, 1'b1);
        if (k == 0) begin
            send(k, 5, 1'b0, 8'h00, 1'b0);
        end else begin
            send(k, 4, 1'b0, 8'h00, 1'b0);
            chk("hpm_accept_state", 64'(st[1]), 64'd4);
            chk("hpm_accept_tx", 64'(tx[1]), 64'd5);
            send(k, 6, 1'b0, 8'h00, 1'b0);
        end
    endtask

    int want;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; typ[k] = 3'd0; crc[k] = 1'b0; miss[k] = 1'b0;
            rcap[k] = 8'h00; lcap[k] = 8'h0F; frc[k] = 1'b0; clr[k] = 1'b0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(st[0]), 64'd0);
        chk("rst_tx", 64'(tx[0]), 64'd1);
        chk("rst_spd", 64'(spd[0]), 64'd0);
        chk("rst_up", 64'(up[1]), 64'd0);
        chk("rst_mism", 64'(mism[1]), 64'd0);
        chk("rst_crccnt", 64'(crcc[0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full training, both roles.
        train(0, 8'h06);
        chk("scm_up_state", 64'(st[0]), 64'd5);
        chk("scm_speed", 64'(spd[0]), 64'h04);
        chk("scm_link_up", 64'(up[0]), 64'd1);
        train(1, 8'h06);
        chk("hpm_up_state", 64'(st[1]), 64'd5);
        chk("hpm_speed", 64'(spd[1]), 64'h04);

        // Operational loss: 2 misses, 1 good, 3 misses.
        send_miss(0); send_miss(0);
        send(0, 6, 1'b0, 8'h00, 1'b0);
        send_miss(0); send_miss(0);
        chk("oper_hold", 64'(st[0]), 64'd5);
        send_miss(0);
        chk("linklost", 64'(st[0]), 64'd6);
        chk("linklost_tx", 64'(tx[0]), 64'd1);
        step();
        chk("lost_to_detect", 64'(st[0]), 64'd0);
        chk("lost_spd_clr", 64'(spd[0]), 64'd0);

        // Detect: a CRC error in the middle restarts the count.
        repeat (6) send(0, 1, 1'b0, 8'h00, 1'b0);
        send(0, 1, 1'b1, 8'h00, 1'b0);
        repeat (6) send(0, 1, 1'b0, 8'h00, 1'b0);
        chk("det_not_yet", 64'(st[0]), 64'd0);
        send(0, 1, 1'b0, 8'h00, 1'b0);
        chk("det_done", 64'(st[0]), 64'd1);

        // Speed mismatch.
        send(0, 2, 1'b0, 8'hF0, 1'b0);
        chk("mism_pulse", 64'(mism[0]), 64'd1);
        chk("mism_state", 64'(st[0]), 64'd0);
        step();
        chk("mism_once", 64'(mism[0]), 64'd0);

        // Advertise timeout.
        repeat (DET) send(0, 1, 1'b0, 8'h00, 1'b0);
        repeat (SPD) send(0, 2, 1'b0, 8'h0C, 1'b0);
        chk("adv_entered", 64'(st[0]), 64'd2);
        repeat (TMO - 1) step();
        chk("adv_before_tmo", 64'(st[0]), 64'd2);
        step();
        chk("adv_tmo", 64'(st[0]), 64'd0);

        // Force retrain from Operational.
        train(0, 8'h0B);
        frc[0] = 1'b1;
        step();
        chk("force_state", 64'(st[0]), 64'd0);
        chk("force_up", 64'(up[0]), 64'd0);
        repeat (DET + 1) send(0, 1, 1'b0, 8'h00, 1'b0);
        chk("force_held", 64'(st[0]), 64'd0);
        frc[0] = 1'b0;
        step();

        // Mid-training asynchronous reset.
        repeat (DET) send(1, 1, 1'b0, 8'h00, 1'b0);
        send(1, 2, 1'b0, 8'h81, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 64'(st[1]), 64'd0);
        chk("async_rst_spd", 64'(spd[1]), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomised traffic, biased towards the frame each model state expects.
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 2; k++) begin
                int e;
                frc[k] = ($urandom_range(0, 199) == 0);
`ifdef LTPI_LINK_ERR_CNT_EN
                clr[k] = ($urandom_range(0, 49) == 0);
`endif
                if (m_st[k] == 6) want = 1;
                else if (k == 1 && m_st[k] == 2 && m_armed[k]) want = 4;
                else want = want_of[m_st[k] == 6 ? 0 : m_st[k]];
                e = int'($urandom_range(0, 19));
                rcap[k] = 8'($urandom);
                if (e < 14) begin
                    vld[k] = 1'b1; typ[k] = 3'(want);
                end else if (e == 14) begin
                    vld[k] = 1'b1; typ[k] = 3'($urandom);
                end else if (e == 15) begin
                    vld[k] = 1'b1; typ[k] = 3'(want); crc[k] = 1'b1;
                end else if (e == 16) begin
                    miss[k] = 1'b1;
                end else if (e == 17) begin
                    miss[k] = 1'b1; vld[k] = 1'b1; typ[k] = 3'(want);
                end
            end
            step();
        end
        frc[0] = 1'b0;
        frc[1] = 1'b0;
        step();

        @(posedge clk);
        #2;
        chk("queue_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
